// File: rtl/fdma_axi_wr_master.sv
// FDMA write engine: turns one (address, beat count) request into 4 KB-safe
// AXI4 INCR write bursts, pulling data beat-by-beat from the granted source.
module fdma_axi_wr_master #(
  parameter int unsigned AXI_DATA_WIDTH    = 128,
  parameter int unsigned AXI_ADDR_WIDTH    = 32,
  parameter int unsigned AXI_MAX_BURST_LEN = 64
) (
  input  logic                          ui_clk,
  input  logic                          ui_rstn,
  input  logic [AXI_ADDR_WIDTH-1:0]     fdma_waddr,
  input  logic                          fdma_wareq,
  input  logic [15:0]                   fdma_wsize,
  output logic                          fdma_wbusy,
  input  logic [AXI_DATA_WIDTH-1:0]     fdma_wdata,
  output logic                          fdma_wvalid,
  output logic                          fdma_werr,
  output logic [AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic [7:0]                    m_axi_awlen,
  output logic [2:0]                    m_axi_awsize,
  output logic [1:0]                    m_axi_awburst,
  output logic                          m_axi_awvalid,
  input  logic                          m_axi_awready,
  output logic [AXI_DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                          m_axi_wlast,
  output logic                          m_axi_wvalid,
  input  logic                          m_axi_wready,
  input  logic [1:0]                    m_axi_bresp,
  input  logic                          m_axi_bvalid,
  output logic                          m_axi_bready
);

  localparam int unsigned BYTES_PER_BEAT = AXI_DATA_WIDTH / 8;
  localparam int unsigned SIZE_LOG2      = $clog2(BYTES_PER_BEAT);

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_AW, S_W, S_B} state_e;

  state_e                      state_q;
  logic [AXI_ADDR_WIDTH-1:0]   addr_q;
  logic [15:0]                 remain_q;
  logic [AXI_ADDR_WIDTH-1:0]   awaddr_q;
  logic [7:0]                  awlen_q;
  logic [7:0]                  beat_q;
  logic                        busy_q;
  logic                        awvalid_q;
  logic                        wvalid_q;
  logic                        wlast_q;
  logic                        bready_q;
  logic                        werr_q;

  logic [12:0]                 bnd_bytes_c;
  logic [12:0]                 bnd_beats_c;
  logic [16:0]                 burst_c;
  logic [7:0]                  awlen_d;
  logic [8:0]                  beats_c;
  logic [AXI_ADDR_WIDTH-1:0]   step_c;

  // Next burst length: limited by remaining beats, max burst and the 4 KB page
  always_comb begin
    bnd_bytes_c = 13'd4096 - {1'b0, addr_q[11:0]};
    bnd_beats_c = bnd_bytes_c >> SIZE_LOG2;
    burst_c     = {1'b0, remain_q};
    if (burst_c > 17'(AXI_MAX_BURST_LEN)) burst_c = 17'(AXI_MAX_BURST_LEN);
    if (burst_c > {4'd0, bnd_beats_c})    burst_c = {4'd0, bnd_beats_c};
    awlen_d     = 8'(burst_c - 17'd1);
    beats_c     = 9'(awlen_q) + 9'd1;
    step_c      = AXI_ADDR_WIDTH'(beats_c) << SIZE_LOG2;
  end

  always_ff @(posedge ui_clk or negedge ui_rstn) begin
    if (!ui_rstn) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      remain_q  <= '0;
      awaddr_q  <= '0;
      awlen_q   <= '0;
      beat_q    <= '0;
      busy_q    <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      wlast_q   <= 1'b0;
      bready_q  <= 1'b0;
      werr_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (fdma_wareq && (fdma_wsize != 16'd0)) begin
            addr_q   <= fdma_waddr;
            remain_q <= fdma_wsize;
            werr_q   <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= S_CALC;
          end
        end
        S_CALC: begin
          awaddr_q  <= addr_q;
          awlen_q   <= awlen_d;
          awvalid_q <= 1'b1;
          state_q   <= S_AW;
        end
        S_AW: begin
          if (m_axi_awready) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b1;
            beat_q    <= 8'd0;
            wlast_q   <= (awlen_q == 8'd0);
            state_q   <= S_W;
          end
        end
        S_W: begin
          if (m_axi_wready) begin
            if (wlast_q) begin
              wvalid_q <= 1'b0;
              wlast_q  <= 1'b0;
              bready_q <= 1'b1;
              addr_q   <= addr_q + step_c;
              remain_q <= remain_q - 16'(beats_c);
              state_q  <= S_B;
            end else begin
              beat_q  <= beat_q + 8'd1;
              wlast_q <= (8'(beat_q + 8'd1) == awlen_q);
            end
          end
        end
        S_B: begin
          if (m_axi_bvalid) begin
            bready_q <= 1'b0;
            if (m_axi_bresp != 2'b00) werr_q <= 1'b1;
            if (remain_q == 16'd0) begin
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              state_q <= S_CALC;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Data path is a pure pass-through so the source FIFO pops in the handshake cycle
  assign fdma_wvalid   = wvalid_q & m_axi_wready;
  assign m_axi_wdata   = wvalid_q ? fdma_wdata : '0;
  assign fdma_wbusy    = busy_q;
  assign fdma_werr     = werr_q;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awlen   = awlen_q;
  assign m_axi_awsize  = 3'(SIZE_LOG2);
  assign m_axi_awburst = 2'b01;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = wlast_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;

endmodule

// File: tb/tb_fdma_axi_wr_master.sv
// Self-checking bench for fdma_axi_wr_master: random AXI slave back-pressure,
// burst plan computed from the 4 KB / max-length rules, data order scoreboard.
module tb_fdma_axi_wr_master;

  logic          ui_clk;
  logic          ui_rstn;
  logic [31:0]   fdma_waddr;
  logic          fdma_wareq;
  logic [15:0]   fdma_wsize;
  logic          fdma_wbusy;
  logic [127:0]  fdma_wdata;
  logic          fdma_wvalid;
  logic          fdma_werr;
  logic [31:0]   m_axi_awaddr;
  logic [7:0]    m_axi_awlen;
  logic [2:0]    m_axi_awsize;
  logic [1:0]    m_axi_awburst;
  logic          m_axi_awvalid;
  logic          m_axi_awready;
  logic [127:0]  m_axi_wdata;
  logic [15:0]   m_axi_wstrb;
  logic          m_axi_wlast;
  logic          m_axi_wvalid;
  logic          m_axi_wready;
  logic [1:0]    m_axi_bresp;
  logic          m_axi_bvalid;
  logic          m_axi_bready;

  fdma_axi_wr_master dut (
    .ui_clk(ui_clk), .ui_rstn(ui_rstn),
    .fdma_waddr(fdma_waddr), .fdma_wareq(fdma_wareq), .fdma_wsize(fdma_wsize),
    .fdma_wbusy(fdma_wbusy), .fdma_wdata(fdma_wdata), .fdma_wvalid(fdma_wvalid),
    .fdma_werr(fdma_werr),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
  );

  initial ui_clk = 1'b0;
  always #5 ui_clk = ~ui_clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [127:0] src_mem [512];
  logic [31:0]  exp_addr_q [$];
  int           exp_len_q  [$];
  int           n_bursts_exp;
  int           src_idx, w_total, wv_count, w_beat, cur_len, b_pending, b_idx;
  int           last_b_cycle;
  int           err_on;
  bit           b_hs, mon_en, resp_en;
  int           aw_pct, w_pct, b_pct;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge ui_clk) cyc <= cyc + 1;

  // Reference burst plan: each burst is min(remaining, 64, beats to next 4 KB page)
  task automatic plan(input logic [31:0] addr, input int size);
    logic [31:0] a;
    int rem, btb, len;
    a = addr;
    rem = size;
    exp_addr_q.delete();
    exp_len_q.delete();
    n_bursts_exp = 0;
    while (rem > 0) begin
      btb = (4096 - int'(a[11:0])) / 16;
      len = rem;
      if (len > 64)  len = 64;
      if (len > btb) len = btb;
      exp_addr_q.push_back(a);
      exp_len_q.push_back(len);
      n_bursts_exp++;
      a   = a + 32'(len * 16);
      rem = rem - len;
    end
  endtask

  task automatic reset_model();
    src_idx = 0; w_total = 0; wv_count = 0; w_beat = 0; cur_len = 0;
    b_pending = 0; b_idx = 0; last_b_cycle = -10; b_hs = 0;
    for (int i = 0; i < 512; i++) src_mem[i] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Slave responder and source FIFO model, updated just after each rising edge
  initial begin
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0;
    fdma_wdata = '0;
    forever begin
      @(posedge ui_clk);
      #1;
      fdma_wdata = (src_idx < 512) ? src_mem[src_idx] : '0;
      if (!resp_en) begin
        m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0; b_hs = 0;
      end else begin
        m_axi_awready = ($urandom_range(99) < aw_pct);
        m_axi_wready  = ($urandom_range(99) < w_pct);
        if (m_axi_bvalid && b_hs) m_axi_bvalid = 0;
        b_hs = 0;
        if (!m_axi_bvalid && b_pending > 0 && $urandom_range(99) < b_pct) begin
          m_axi_bvalid = 1;
          m_axi_bresp  = (b_idx == err_on) ? 2'b10 : 2'b00;
        end
      end
    end
  end

  // Bus monitor, sampled mid-cycle
  always @(negedge ui_clk) begin
    if (mon_en) begin
      if (m_axi_awvalid && m_axi_awready) begin
        if (exp_addr_q.size() == 0) begin
          chk("aw_unexpected", 128'(m_axi_awaddr), 128'(0));
          cur_len = int'(m_axi_awlen) + 1;
        end else begin
          chk("awaddr", 128'(m_axi_awaddr), 128'(exp_addr_q.pop_front()));
          cur_len = exp_len_q.pop_front();
          chk("awlen", 128'(m_axi_awlen), 128'(cur_len - 1));
        end
        w_beat = 0;
      end
      if (m_axi_wvalid && m_axi_wready) begin
        chk("wdata", m_axi_wdata, (w_total < 512) ? src_mem[w_total] : '0);
        chk("wlast", 128'(m_axi_wlast), 128'(w_beat == cur_len - 1));
        w_beat++;
        w_total++;
        if (m_axi_wlast) b_pending++;
      end
      if (fdma_wvalid) begin
        src_idx++;
        wv_count++;
      end
      if (m_axi_bvalid && m_axi_bready) begin
        b_pending--;
        b_idx++;
        last_b_cycle = cyc;
        b_hs = 1;
      end
    end
  end

  task automatic xfer(input logic [31:0] addr, input int size, input int err_idx,
                      input bit exp_err, input bit pulse_busy);
    int cnt;
    plan(addr, size);
    reset_model();
    err_on = err_idx;
    @(posedge ui_clk); #1;
    fdma_waddr = addr; fdma_wsize = 16'(size); fdma_wareq = 1;
    @(negedge ui_clk);
    chk("busy_at_accept", 128'(fdma_wbusy), 128'(0));
    chk("wdata_idle", m_axi_wdata, 128'(0));
    @(posedge ui_clk); #1;
    fdma_wareq = 0;
    @(negedge ui_clk);
    chk("busy_n1", 128'(fdma_wbusy), 128'(1));
    chk("werr_clear", 128'(fdma_werr), 128'(0));
    chk("awvalid_n1", 128'(m_axi_awvalid), 128'(0));
    @(negedge ui_clk);
    chk("awvalid_n2", 128'(m_axi_awvalid), 128'(1));
    if (pulse_busy) begin
      @(posedge ui_clk); #1;
      fdma_waddr = 32'h0008_0000; fdma_wsize = 16'd5; fdma_wareq = 1;
      @(posedge ui_clk); #1;
      fdma_wareq = 0;
      @(negedge ui_clk);
    end
    cnt = 0;
    while (fdma_wbusy && cnt < 20000) begin
      @(negedge ui_clk);
      cnt++;
    end
    chk("done_timeout", 128'(cnt >= 20000), 128'(0));
    chk("busy_fall", 128'(cyc), 128'(last_b_cycle + 1));
    chk("fdma_wvalid_cnt", 128'(wv_count), 128'(size));
    chk("w_beats", 128'(w_total), 128'(size));
    chk("bursts_left", 128'(exp_addr_q.size()), 128'(0));
    chk("b_count", 128'(b_idx), 128'(n_bursts_exp));
    chk("werr", 128'(fdma_werr), 128'(exp_err));
    repeat (2) @(negedge ui_clk);
  endtask

  initial begin
    int cnt;
    logic [31:0] a;
    ui_rstn = 0; fdma_wareq = 0; fdma_waddr = '0; fdma_wsize = '0;
    mon_en = 0; resp_en = 0; err_on = -1;
    aw_pct = 100; w_pct = 100; b_pct = 100;
    reset_model();
    repeat (3) @(negedge ui_clk);
    chk("rst_busy", 128'(fdma_wbusy), 128'(0));
    chk("rst_awvalid", 128'(m_axi_awvalid), 128'(0));
    chk("rst_wvalid", 128'(m_axi_wvalid), 128'(0));
    chk("rst_bready", 128'(m_axi_bready), 128'(0));
    chk("rst_werr", 128'(fdma_werr), 128'(0));
    chk("rst_wdata", m_axi_wdata, 128'(0));
    chk("awsize", 128'(m_axi_awsize), 128'(4));
    chk("awburst", 128'(m_axi_awburst), 128'(1));
    chk("wstrb", 128'(m_axi_wstrb), 128'(16'hFFFF));
    @(posedge ui_clk); #1;
    ui_rstn = 1; resp_en = 1; mon_en = 1;

    xfer(32'h0000_0000, 64, -1, 0, 0);
    xfer(32'h0001_0000, 100, -1, 0, 0);
    xfer(32'h0000_0FC0, 16, -1, 0, 0);

    aw_pct = 70; w_pct = 50; b_pct = 60;
    for (int i = 0; i < 6; i++) begin
      a = $urandom & 32'hFFFF_FFF0;
      if ($urandom_range(1) == 1) a = (a & 32'hFFFF_F000) | 32'(4096 - 16 * $urandom_range(1, 20));
      xfer(a, $urandom_range(1, 300), -1, 0, 0);
    end

    xfer(32'h0000_2000, 40, -1, 0, 1);
    chk("no_latched_req", 128'(fdma_wbusy), 128'(0));

    xfer(32'h0001_0000, 100, 1, 1, 0);
    repeat (3) @(negedge ui_clk);
    chk("werr_sticky", 128'(fdma_werr), 128'(1));
    @(posedge ui_clk); #1;
    fdma_wsize = 16'd0; fdma_wareq = 1;
    @(posedge ui_clk); #1;
    fdma_wareq = 0;
    repeat (3) @(negedge ui_clk);
    chk("size0_busy", 128'(fdma_wbusy), 128'(0));
    chk("size0_awvalid", 128'(m_axi_awvalid), 128'(0));
    chk("size0_werr", 128'(fdma_werr), 128'(1));
    xfer(32'h0000_3000, 20, -1, 0, 0);

    // Reset in the middle of a W burst
    aw_pct = 100; w_pct = 100; b_pct = 100;
    plan(32'h0000_4000, 200);
    reset_model();
    err_on = -1;
    @(posedge ui_clk); #1;
    fdma_waddr = 32'h0000_4000; fdma_wsize = 16'd200; fdma_wareq = 1;
    @(posedge ui_clk); #1;
    fdma_wareq = 0;
    cnt = 0;
    while (!(m_axi_wvalid && w_total >= 10) && cnt < 1000) begin
      @(negedge ui_clk);
      cnt++;
    end
    chk("mid_w_timeout", 128'(cnt >= 1000), 128'(0));
    @(posedge ui_clk); #1;
    mon_en = 0; resp_en = 0;
    ui_rstn = 0;
    #1;
    chk("arst_busy", 128'(fdma_wbusy), 128'(0));
    chk("arst_awvalid", 128'(m_axi_awvalid), 128'(0));
    chk("arst_wvalid", 128'(m_axi_wvalid), 128'(0));
    chk("arst_fdma_wvalid", 128'(fdma_wvalid), 128'(0));
    chk("arst_bready", 128'(m_axi_bready), 128'(0));
    chk("arst_werr", 128'(fdma_werr), 128'(0));
    chk("arst_wdata", m_axi_wdata, 128'(0));
    repeat (2) @(posedge ui_clk);
    #1;
    ui_rstn = 1; resp_en = 1; mon_en = 1;
    xfer(32'h0000_5000, 70, -1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
